casc_down_counter: RTL and testbench

Registered, cascadable, loadable down-counter built from 4-bit slices, with a ripple borrow chain and terminal-count signalling. It is the counting-down counterpart of the team's combinational up-count/load slice benchmark: it holds state, consumes a count strobe, and emits the borrow that a downstream stage consumes. It sits in the sequential train_set alongside the combinational benchmarks, as a synthesis/power test vehicle with real state.

---
 rtl/casc_cnt_pkg.sv | 12 +
 rtl/down4_slice.sv | 35 +++
 rtl/casc_down_counter.sv | 84 ++++++++
 tb/tb_casc_down_counter.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/casc_cnt_pkg.sv
// Shared constants and helpers for the cascadable down-counter.
package casc_cnt_pkg;

   // Width of one counter slice.
   localparam int SLICE_W = 4;

   // Total counter width for a given number of slices.
   function automatic int cnt_width(input int slices);
      return slices * SLICE_W;
   endfunction

endpackage

// File: rtl/down4_slice.sv
// One 4-bit down-counting slice: loadable register with a borrow-in
// decrement and a combinational borrow-out for the next slice up.
module down4_slice
   import casc_cnt_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               load,
   input  logic [SLICE_W-1:0] next_val,
   input  logic               bin,
   output logic [SLICE_W-1:0] q,
   output logic               bout
);

   logic [SLICE_W-1:0] q_reg;

   // Load wins over decrement; decrement only when borrow arrives from below.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_reg <= '0;
      end else if (load) begin
         q_reg <= next_val;
      end else if (bin) begin
         q_reg <= q_reg - SLICE_W'(1);
      end
   end

   // Borrow propagates upward only when this slice is about to underflow.
   always_comb begin
      bout = bin & (q_reg == '0);
   end

   assign q = q_reg;

endmodule

// File: rtl/casc_down_counter.sv
// Cascadable loadable down-counter built from 4-bit slices with a ripple
// borrow chain, optional auto-reload on underflow and a terminal-count pulse.
module casc_down_counter
   import casc_cnt_pkg::*;
#(
   parameter int SLICES      = 4,
   parameter bit AUTO_RELOAD = 1'b0
)(
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          load,
   input  logic [cnt_width(SLICES)-1:0]  load_val,
   input  logic                          en,
   input  logic                          bin,
   output logic [cnt_width(SLICES)-1:0]  q,
   output logic                          zero,
   output logic                          bout,
   output logic                          done
);

   localparam int W = cnt_width(SLICES);

   logic [W-1:0]    reload_reg;
   logic            done_reg;
   logic            count_step;
   logic            reload_hit;
   logic            slice_load;
   logic [W-1:0]    slice_val;
   logic [SLICES:0] borrow_chain;
   logic [W-1:0]    q_next;

   // A count strobe is honoured only when no load is competing for the edge.
   // With auto-reload, underflow is expressed as a load of the reload value
   // so the slices' own load-over-decrement priority suppresses the wrap.
   always_comb begin
      count_step      = en & bin & ~load;
      reload_hit      = AUTO_RELOAD & count_step & zero;
      slice_load      = load | reload_hit;
      slice_val       = load ? load_val : reload_reg;
      borrow_chain[0] = count_step;
   end

   generate
      for (genvar gi = 0; gi < SLICES; gi++) begin : g_slice
         down4_slice u_slice (
            .clk      (clk),
            .rst      (rst),
            .load     (slice_load),
            .next_val (slice_val[gi*SLICE_W +: SLICE_W]),
            .bin      (borrow_chain[gi]),
            .q        (q_next[gi*SLICE_W +: SLICE_W]),
            .bout     (borrow_chain[gi+1])
         );
      end
   endgenerate

   // The reload register captures every explicit load value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         reload_reg <= '0;
      end else if (load) begin
         reload_reg <= load_val;
      end
   end

   // Terminal-count pulse: only a count step from 1 to 0 raises it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         done_reg <= 1'b0;
      end else begin
         done_reg <= count_step && (q_next == {{(W-1){1'b0}}, 1'b1});
      end
   end

   // Zero detect and borrow-out are combinational so cascades ripple in-cycle.
   always_comb begin
      zero = (q_next == '0);
      bout = borrow_chain[SLICES];
   end

   assign q    = q_next;
   assign done = done_reg;

endmodule

// File: tb/tb_casc_down_counter.sv
// Directed bench for casc_down_counter: wrap and reload variants plus a
// two-stage cascade of single-slice counters.
module tb_casc_down_counter;

   logic clk = 1'b0;
   logic rst;

   // 16-bit wrapping counter
   logic        a_load, a_en, a_bin;
   logic [15:0] a_load_val, a_q;
   logic        a_zero, a_bout, a_done;

   // 16-bit auto-reload counter
   logic        r_load, r_en, r_bin;
   logic [15:0] r_load_val, r_q;
   logic        r_zero, r_bout, r_done;

   // Cascade of two 4-bit counters
   logic        c_en, c0_load, c1_load, c0_bin;
   logic [3:0]  c0_load_val, c1_load_val, c0_q, c1_q;
   logic        c0_zero, c0_bout, c0_done, c1_zero, c1_bout, c1_done;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   casc_down_counter #(.SLICES(4), .AUTO_RELOAD(1'b0)) u_a (
      .clk(clk), .rst(rst), .load(a_load), .load_val(a_load_val), .en(a_en),
      .bin(a_bin), .q(a_q), .zero(a_zero), .bout(a_bout), .done(a_done));

   casc_down_counter #(.SLICES(4), .AUTO_RELOAD(1'b1)) u_r (
      .clk(clk), .rst(rst), .load(r_load), .load_val(r_load_val), .en(r_en),
      .bin(r_bin), .q(r_q), .zero(r_zero), .bout(r_bout), .done(r_done));

   casc_down_counter #(.SLICES(1), .AUTO_RELOAD(1'b0)) u_c0 (
      .clk(clk), .rst(rst), .load(c0_load), .load_val(c0_load_val), .en(c_en),
      .bin(c0_bin), .q(c0_q), .zero(c0_zero), .bout(c0_bout), .done(c0_done));

   casc_down_counter #(.SLICES(1), .AUTO_RELOAD(1'b0)) u_c1 (
      .clk(clk), .rst(rst), .load(c1_load), .load_val(c1_load_val), .en(c_en),
      .bin(c0_bout), .q(c1_q), .zero(c1_zero), .bout(c1_bout), .done(c1_done));

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      a_load = 0; a_en = 0; a_bin = 0; a_load_val = '0;
      r_load = 0; r_en = 0; r_bin = 0; r_load_val = '0;
      c_en = 0; c0_load = 0; c1_load = 0; c0_bin = 0; c0_load_val = '0; c1_load_val = '0;

      // Reset state
      #2;
      chk("rst_a_q", a_q, 16'h0000);
      chk("rst_a_zero", {15'd0, a_zero}, 16'd1);
      chk("rst_a_done", {15'd0, a_done}, 16'd0);
      chk("rst_a_bout_idle", {15'd0, a_bout}, 16'd0);
      chk("rst_r_q", r_q, 16'h0000);
      a_en = 1; a_bin = 1; #1;
      chk("rst_a_bout_strobe", {15'd0, a_bout}, 16'd1);
      a_en = 0; a_bin = 0;
      @(posedge clk); #1;
      rst = 1'b0;

      // Load 3 then count down to 0
      a_load = 1; a_load_val = 16'h0003; a_en = 1; a_bin = 1; #1;
      chk("ld3_bout", {15'd0, a_bout}, 16'd0);
      tick();
      chk("ld3_q", a_q, 16'h0003);
      chk("ld3_done", {15'd0, a_done}, 16'd0);
      a_load = 0; #1;
      chk("cnt3_bout", {15'd0, a_bout}, 16'd0);
      tick();
      chk("cnt_q2", a_q, 16'h0002);
      tick();
      chk("cnt_q1", a_q, 16'h0001);
      chk("cnt_q1_done", {15'd0, a_done}, 16'd0);
      tick();
      chk("cnt_q0", a_q, 16'h0000);
      chk("cnt_q0_done", {15'd0, a_done}, 16'd1);
      chk("cnt_q0_bout", {15'd0, a_bout}, 16'd1);
      a_en = 0; #1;
      chk("en0_bout", {15'd0, a_bout}, 16'd0);
      tick();
      chk("en0_hold_q", a_q, 16'h0000);
      chk("done_width", {15'd0, a_done}, 16'd0);

      // Wrap from 0
      a_en = 1; tick();
      chk("wrap_q", a_q, 16'hFFFF);
      chk("wrap_done", {15'd0, a_done}, 16'd0);
      chk("wrap_zero", {15'd0, a_zero}, 16'd0);

      // Slice borrow across slice 1
      a_load = 1; a_load_val = 16'h0100; tick();
      chk("ld100_q", a_q, 16'h0100);
      a_load = 0; tick();
      chk("borrow_q", a_q, 16'h00FF);

      // bin low holds
      a_bin = 0; tick();
      chk("bin0_hold", a_q, 16'h00FF);
      a_bin = 1;

      // Load beats a coincident count from 1
      a_load = 1; a_load_val = 16'h0001; tick();
      chk("ld1_q", a_q, 16'h0001);
      a_load_val = 16'h0010; tick();
      chk("ldcnt_q", a_q, 16'h0010);
      chk("ldcnt_done", {15'd0, a_done}, 16'd0);
      a_load_val = 16'h0000; tick();
      chk("ld0_done", {15'd0, a_done}, 16'd0);
      a_load = 0; a_en = 0;

      // Auto-reload counter
      r_load = 1; r_load_val = 16'h0005; r_en = 1; r_bin = 1; tick();
      chk("r_ld5", r_q, 16'h0005);
      r_load = 0;
      tick(); tick(); tick(); tick();
      chk("r_q1", r_q, 16'h0001);
      tick();
      chk("r_q0", r_q, 16'h0000);
      chk("r_q0_done", {15'd0, r_done}, 16'd1);
      tick();
      chk("r_reload_q", r_q, 16'h0005);
      chk("r_reload_done", {15'd0, r_done}, 16'd0);
      r_load = 1; r_load_val = 16'h0000; tick();
      r_load = 0; #1;
      chk("r_zero_bout", {15'd0, r_bout}, 16'd1);
      tick();
      chk("r_reload0_q", r_q, 16'h0000);
      chk("r_reload0_done", {15'd0, r_done}, 16'd0);
      r_en = 0;

      // Cascade: stage 1 steps only when stage 0 is at 0 and counting
      c0_load = 1; c1_load = 1; c0_load_val = 4'h2; c1_load_val = 4'h3; c_en = 1; c0_bin = 1;
      tick();
      chk("c_ld", {8'd0, c1_q, c0_q}, 16'h0032);
      c0_load = 0; c1_load = 0; #1;
      chk("c_bout_nz", {15'd0, c0_bout}, 16'd0);
      tick();
      chk("c_step1", {8'd0, c1_q, c0_q}, 16'h0031);
      tick();
      chk("c_step2", {8'd0, c1_q, c0_q}, 16'h0030);
      chk("c_bout_z", {15'd0, c0_bout}, 16'd1);
      tick();
      chk("c_step3", {8'd0, c1_q, c0_q}, 16'h002F);
      tick();
      chk("c_step4", {8'd0, c1_q, c0_q}, 16'h002E);
      c_en = 0;

      // Asynchronous reset mid-cycle drops q and a pending done
      a_load = 1; a_load_val = 16'h0124; a_en = 1; a_bin = 1;
      r_load = 1; r_load_val = 16'h0001; r_en = 1; r_bin = 1;
      tick();
      a_load = 0; r_load = 0;
      tick();
      chk("pre_rst_a_q", a_q, 16'h0123);
      chk("pre_rst_r_done", {15'd0, r_done}, 16'd1);
      #2 rst = 1'b1; #1;
      chk("async_rst_a_q", a_q, 16'h0000);
      chk("async_rst_a_zero", {15'd0, a_zero}, 16'd1);
      chk("async_rst_r_done", {15'd0, r_done}, 16'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      tick();
      chk("post_rst_a_wrap", a_q, 16'hFFFF);
      chk("post_rst_r_q", r_q, 16'h0000);
      chk("post_rst_r_done", {15'd0, r_done}, 16'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
